// File: rtl/pad_encoder4.sv
// Four-line pad encoder: synchronizes and debounces four raw pad lines, then
// encodes each debounced press into a 2-bit index held under a valid/ack handshake.
module pad_encoder4 #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Din,
  input  logic       Ack,
  output logic [1:0] Code,
  output logic       Valid,
  output logic       Overrun
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state;
  logic [3:0] sync1;
  logic [3:0] s;
  logic [3:0] db;
  logic [7:0] cnt [4];

  logic [3:0] press;
  logic       any_press;
  logic       multi_press;
  logic [1:0] win_idx;
  logic       drop;

  // Two-flop synchronizer; the first stage may go metastable, only s is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      sync1 <= Din;
      s     <= sync1;
    end
  end

  // NOTE: the counter array is tiny and must start at zero, so it is reset like plain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST_CNT) begin
          db[i]  <= s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    press = '0;
    for (int i = 0; i < 4; i++) begin
      press[i] = s[i] & ~db[i] & (cnt[i] == LAST_CNT);
    end
  end

  // Highest index wins; any other simultaneous press is a drop.
  always_comb begin
    any_press   = |press;
    multi_press = (press & (press - 4'd1)) != 4'd0;
    if (press[3])      win_idx = 2'd3;
    else if (press[2]) win_idx = 2'd2;
    else if (press[1]) win_idx = 2'd1;
    else               win_idx = 2'd0;
  end

  always_comb begin
    drop = 1'b0;
    if (any_press) begin
      if (state == HOLD && !Ack) drop = 1'b1;
      else                       drop = multi_press;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      Code    <= '0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      Overrun <= drop;
      case (state)
        IDLE: begin
          if (any_press) begin
            Code  <= win_idx;
            Valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (Ack) begin
            if (any_press) begin
              Code <= win_idx;
            end else begin
              Valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_encoder4.sv
// Directed-vector bench for pad_encoder4 with DEBOUNCE_CYCLES=4.
module tb_pad_encoder4;

  logic       clk;
  logic       rst_n;
  logic [3:0] Din;
  logic       Ack;
  logic [1:0] Code;
  logic       Valid;
  logic       Overrun;

  int n_checks = 0;
  int n_fail   = 0;

  pad_encoder4 #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Din     (Din),
    .Ack     (Ack),
    .Code    (Code),
    .Valid   (Valid),
    .Overrun (Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] c, input logic o);
    check({tag, " valid"},   32'(Valid),   32'(v));
    check({tag, " code"},    32'(Code),    32'(c));
    check({tag, " overrun"}, 32'(Overrun), 32'(o));
  endtask

  // Ack the held code, then release all lines and let debounced state settle low.
  task automatic ack_and_release();
    Ack = 1'b1;
    tick(1);
    Ack = 1'b0;
    Din = 4'b0000;
    tick(8);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    Din   = 4'b0000;
    Ack   = 1'b0;
    #1;
    check_out("reset", 1'b0, 2'd0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Single clean press on line 2: Valid appears on the 6th edge after the change.
    Din = 4'b0100;
    tick(5);
    check_out("press2 early", 1'b0, 2'd0, 1'b0);
    tick(1);
    check_out("press2 rise", 1'b1, 2'd2, 1'b0);
    tick(3);
    check_out("press2 hold", 1'b1, 2'd2, 1'b0);
    Ack = 1'b1;
    tick(1);
    check("press2 acked valid", 32'(Valid), 32'd0);
    check("press2 code kept", 32'(Code), 32'd2);
    Ack = 1'b0;
    Din = 4'b0000;
    tick(8);

    // Bounce on line 1: 1,0,1,0 then held high.
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Din = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(1);
      seen |= Valid;
    end
    Din = 4'b0010;
    tick(5);
    seen |= Valid;
    check("bounce no valid", 32'(seen), 32'd0);
    tick(1);
    check_out("bounce press", 1'b1, 2'd1, 1'b0);
    ack_and_release();
    check("bounce released valid", 32'(Valid), 32'd0);

    // Simultaneous 1011: line 3 wins, lines 0 and 1 dropped -> single Overrun pulse.
    Din = 4'b1011;
    tick(6);
    check_out("simul press", 1'b1, 2'd3, 1'b1);
    tick(1);
    check_out("simul after", 1'b1, 2'd3, 1'b0);
    ack_and_release();

    // Hold code 0, then line 2 completes debounce with Ack=0: dropped.
    Din = 4'b0001;
    tick(6);
    check_out("hold0 load", 1'b1, 2'd0, 1'b0);
    Din = 4'b0101;
    tick(5);
    check_out("hold0 pre drop", 1'b1, 2'd0, 1'b0);
    tick(1);
    check_out("hold0 drop", 1'b1, 2'd0, 1'b1);
    tick(1);
    check_out("hold0 drop end", 1'b1, 2'd0, 1'b0);
    // Release line 2, then re-press so its debounce completes on the Ack cycle.
    Din = 4'b0001;
    tick(8);
    Din = 4'b0101;
    tick(5);
    check_out("hold0 pre reload", 1'b1, 2'd0, 1'b0);
    Ack = 1'b1;
    tick(1);
    Ack = 1'b0;
    check_out("ack reload", 1'b1, 2'd2, 1'b0);
    tick(2);
    check_out("reload hold", 1'b1, 2'd2, 1'b0);
    ack_and_release();
    check("reload released valid", 32'(Valid), 32'd0);

    // Release shorter than the debounce window: no second press.
    Din = 4'b1000;
    tick(6);
    check_out("line3 press", 1'b1, 2'd3, 1'b0);
    Ack = 1'b1;
    tick(1);
    Ack = 1'b0;
    check("line3 acked", 32'(Valid), 32'd0);
    Din = 4'b0000;
    tick(3);
    Din = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen |= Valid;
    end
    check("short release no repress", 32'(seen), 32'd0);

    // Release long enough for db to fall: a second press follows.
    Din = 4'b0000;
    tick(5);
    Din = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(1);
      seen = Valid;
    end
    check("long release repress", 32'(seen), 32'd1);
    check("repress code", 32'(Code), 32'd3);

    // Asynchronous reset in the middle of HOLD.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async reset", 1'b0, 2'd0, 1'b0);
    Din = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen |= Valid | Overrun | (Code != 2'd0);
    end
    check("idle after reset", 32'(seen), 32'd0);
    check_out("idle end", 1'b0, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
